// File: rtl/atomic_rd_pkg.sv
// Shared types for the two-beat atomic counter reader.
//  state_e : reader FSM states
//  beat_e  : which half of the 64-bit sample a state works on
//  beat_of : maps a state to its beat (drives atomic_o)
package atomic_rd_pkg;

   localparam int HALF_W_DEFAULT = 32;

   typedef enum logic [2:0] {
      IDLE,
      REQ_LO,
      WAIT_LO,
      REQ_HI,
      WAIT_HI,
      DONE
   } state_e;

   typedef enum logic {
      BEAT_LO,
      BEAT_HI
   } beat_e;

   function automatic beat_e beat_of(input state_e s);
      return (s == REQ_HI || s == WAIT_HI || s == DONE) ? BEAT_HI : BEAT_LO;
   endfunction

   function automatic logic is_req(input state_e s);
      return (s == REQ_LO || s == REQ_HI);
   endfunction

endpackage

// File: rtl/ack_wait_timer.sv
// Per-beat acknowledge timer.
//  clk, reset : clock, asynchronous active-high reset
//  clr_i      : force count to zero (takes priority over en_i)
//  en_i       : advance count by one
//  expire_o   : high while count == TIMEOUT_CYCLES-1
module ack_wait_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expire_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/atomic_counter_reader.sv
// Initiator for the two-beat atomic counter read. A start pulse issues an atomic
// low-half request followed by a plain high-half request, assembles {hi,lo},
// and publishes the sample together with its modular difference from the
// previous sample.
//  clk, reset  : clock, asynchronous active-high reset
//  start_i     : begin one read (dropped while busy_o)
//  req_o       : one-cycle request strobe per beat
//  atomic_o    : 1 on the low-half (atomic) beat
//  ack_i       : responder acknowledge, count_i valid with it
//  count_i     : response data for the current beat
//  busy_o      : read in progress
//  valid_o     : one-cycle pulse, value_o/delta_o just updated
//  value_o     : last completed sample {hi,lo}
//  delta_o     : value_o minus the previous sample, modulo 2^(2*HALF_W)
//  timeout_o   : one-cycle pulse, read aborted with outputs untouched
module atomic_counter_reader
   import atomic_rd_pkg::*;
#(
   parameter int HALF_W         = HALF_W_DEFAULT,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   output logic                  req_o,
   output logic                  atomic_o,
   input  logic                  ack_i,
   input  logic [HALF_W-1:0]     count_i,
   output logic                  busy_o,
   output logic                  valid_o,
   output logic [2*HALF_W-1:0]   value_o,
   output logic [2*HALF_W-1:0]   delta_o,
   output logic                  timeout_o
);

   localparam int SW = 2 * HALF_W;

   state_e            state_q, state_d;
   logic              req_q, req_d;
   logic              atomic_q, atomic_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic              timeout_q, timeout_d;
   logic [HALF_W-1:0] lo_q, lo_d;
   logic [SW-1:0]     value_q, value_d;
   logic [SW-1:0]     delta_q, delta_d;
   logic [SW-1:0]     prev_q, prev_d;
   logic [SW-1:0]     sample;

   logic tmr_clr, tmr_en, tmr_expire;

   ack_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (tmr_clr),
      .en_i     (tmr_en),
      .expire_o (tmr_expire)
   );

   // The high half arrives on the same cycle the sample is published, so the
   // result is assembled straight from count_i rather than via a hi register;
   // this keeps valid_o five cycles after start with a one-cycle responder.
   assign sample = {count_i, lo_q};

   always_comb begin
      state_d   = state_q;
      lo_d      = lo_q;
      value_d   = value_q;
      delta_d   = delta_q;
      prev_d    = prev_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;

      case (state_q)
         IDLE:    if (start_i) state_d = REQ_LO;
         REQ_LO:  state_d = WAIT_LO;
         WAIT_LO: begin
            if (ack_i) begin
               lo_d    = count_i;
               state_d = REQ_HI;
            end else if (tmr_expire) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end
         end
         REQ_HI:  state_d = WAIT_HI;
         WAIT_HI: begin
            if (ack_i) begin
               value_d = sample;
               delta_d = sample - prev_q;
               prev_d  = sample;
               valid_d = 1'b1;
               state_d = DONE;
            end else if (tmr_expire) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Timer is zero during the request cycle and counts it, so expiry
      // lands exactly TIMEOUT_CYCLES cycles after the req_o strobe.
      tmr_clr = is_req(state_d);
      tmr_en  = is_req(state_q) || state_q == WAIT_LO || state_q == WAIT_HI;

      // Outputs are decoded from the next state so they appear registered.
      req_d    = is_req(state_d);
      atomic_d = (state_d == REQ_LO) && (beat_of(state_d) == BEAT_LO);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         atomic_q  <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         lo_q      <= '0;
         value_q   <= '0;
         delta_q   <= '0;
         prev_q    <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         atomic_q  <= atomic_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         lo_q      <= lo_d;
         value_q   <= value_d;
         delta_q   <= delta_d;
         prev_q    <= prev_d;
      end
   end

   assign req_o     = req_q;
   assign atomic_o  = atomic_q;
   assign busy_o    = busy_q;
   assign valid_o   = valid_q;
   assign timeout_o = timeout_q;
   assign value_o   = value_q;
   assign delta_o   = delta_q;

endmodule

// File: tb/tb_atomic_counter_reader.sv
// Directed bench for atomic_counter_reader with a snapshotting responder model.
module tb_atomic_counter_reader;

   localparam int HALF_W = 32;
   localparam int TO     = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_i = 1'b0;
   logic        req_o, atomic_o, busy_o, valid_o, timeout_o;
   logic        ack_i;
   logic [31:0] count_i;
   logic [63:0] value_o, delta_o;

   atomic_counter_reader #(
      .HALF_W         (HALF_W),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start_i   (start_i),
      .req_o     (req_o),
      .atomic_o  (atomic_o),
      .ack_i     (ack_i),
      .count_i   (count_i),
      .busy_o    (busy_o),
      .valid_o   (valid_o),
      .value_o   (value_o),
      .delta_o   (delta_o),
      .timeout_o (timeout_o)
   );

   always #5 clk = ~clk;

   // Responder: acks one cycle after each req_o; atomic beat returns lo and
   // snapshots hi, plain beat returns the snapshot.
   logic        ack_resp = 1'b0, ack_man = 1'b0;
   logic [31:0] count_resp = '0, count_man = '0;
   logic [63:0] cnt = '0;
   logic [31:0] hi_snap = '0;
   bit          silent_hi = 1'b0, bump = 1'b0, pend = 1'b0, pend_atomic = 1'b0;

   assign ack_i   = ack_resp | ack_man;
   assign count_i = ack_resp ? count_resp : count_man;

   always @(negedge clk) begin
      pend        = (req_o === 1'b1) && !(silent_hi && atomic_o !== 1'b1);
      pend_atomic = (atomic_o === 1'b1);
   end

   always @(posedge clk) begin
      #1;
      ack_resp = pend;
      if (pend) begin
         if (pend_atomic) begin
            count_resp = cnt[31:0];
            hi_snap    = cnt[63:32];
            if (bump) cnt = cnt + 64'd1;
         end else begin
            count_resp = hi_snap;
         end
      end
   end

   int req_cnt = 0, valid_cnt = 0, to_cnt = 0;
   always @(negedge clk) begin
      if (req_o === 1'b1)     req_cnt++;
      if (valid_o === 1'b1)   valid_cnt++;
      if (timeout_o === 1'b1) to_cnt++;
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic do_read(input logic [63:0] v);
      int k;
      cnt = v;
      @(negedge clk); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      k = 0;
      while (valid_o !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk1("read_valid_seen", valid_o, 1'b1);
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk1("rst_req", req_o, 1'b0);
      chk1("rst_busy", busy_o, 1'b0);
      chk1("rst_valid", valid_o, 1'b0);
      chk1("rst_timeout", timeout_o, 1'b0);
      chk("rst_value", value_o, 64'h0);
      chk("rst_delta", delta_o, 64'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // 1: cycle-exact latency
      cnt = 64'h0000_0001_FFFF_FFFF;
      @(negedge clk); start_i = 1'b1;            // c0
      @(negedge clk); start_i = 1'b0;            // c1
      chk1("t1_req_c1", req_o, 1'b1);
      chk1("t1_atomic_c1", atomic_o, 1'b1);
      chk1("t1_busy_c1", busy_o, 1'b1);
      @(negedge clk);                            // c2
      chk1("t1_req_c2", req_o, 1'b0);
      @(negedge clk);                            // c3
      chk1("t1_req_c3", req_o, 1'b1);
      chk1("t1_atomic_c3", atomic_o, 1'b0);
      @(negedge clk);                            // c4
      chk1("t1_valid_c4", valid_o, 1'b0);
      @(negedge clk);                            // c5
      chk1("t1_valid_c5", valid_o, 1'b1);
      chk("t1_value", value_o, 64'h0000_0001_FFFF_FFFF);
      chk("t1_delta", delta_o, 64'h0000_0001_FFFF_FFFF);
      @(negedge clk);                            // c6
      chk1("t1_valid_c6", valid_o, 1'b0);
      chk1("t1_busy_c6", busy_o, 1'b0);
      chk("t1_value_held", value_o, 64'h0000_0001_FFFF_FFFF);

      // 2: counter rolls between beats, snapshot must win
      bump = 1'b1;
      do_read(64'h0000_0005_FFFF_FFFF);
      bump = 1'b0;
      chk("t2_value", value_o, 64'h0000_0005_FFFF_FFFF);
      chk("t2_delta", delta_o, 64'h0000_0004_0000_0000);

      // 3: deltas, including wrap
      do_read(64'h10);
      chk("t3_value_10", value_o, 64'h10);
      do_read(64'h35);
      chk("t3_delta_25", delta_o, 64'h25);
      do_read(64'hFFFF_FFFF_FFFF_FFFE);
      chk("t3_value_max", value_o, 64'hFFFF_FFFF_FFFF_FFFE);
      do_read(64'h1);
      chk("t3_value_1", value_o, 64'h1);
      chk("t3_delta_wrap", delta_o, 64'h3);

      // 4: silent high beat -> timeout 16 cycles after req #2
      silent_hi = 1'b1;
      cnt = 64'h77;
      @(negedge clk); start_i = 1'b1;            // c0
      @(negedge clk); start_i = 1'b0;            // c1
      @(negedge clk);                            // c2
      @(negedge clk);                            // c3
      chk1("t4_req2", req_o, 1'b1);
      chk1("t4_req2_atomic", atomic_o, 1'b0);
      for (int i = 1; i < TO; i++) begin
         @(negedge clk);
         chk1("t4_no_early_timeout", timeout_o, 1'b0);
      end
      @(negedge clk);                            // c3 + 16
      chk1("t4_timeout", timeout_o, 1'b1);
      chk1("t4_busy_drop", busy_o, 1'b0);
      chk1("t4_no_valid", valid_o, 1'b0);
      chk("t4_value_kept", value_o, 64'h1);
      @(negedge clk);
      chk1("t4_timeout_pulse", timeout_o, 1'b0);
      silent_hi = 1'b0;
      do_read(64'h100);
      chk("t4_next_value", value_o, 64'h100);
      chk("t4_next_delta", delta_o, 64'hFF);

      // 5: stray acks and start while busy
      repeat (2) @(negedge clk);
      req_cnt = 0; valid_cnt = 0; to_cnt = 0;
      ack_man = 1'b1; count_man = 32'hDEAD;
      @(negedge clk); ack_man = 1'b0;
      chk1("t5_idle_ack_busy", busy_o, 1'b0);
      chk1("t5_idle_ack_valid", valid_o, 1'b0);
      cnt = 64'h42;
      start_i = 1'b1;                            // c0
      @(negedge clk); start_i = 1'b0;            // c1 (REQ_LO)
      ack_man = 1'b1; count_man = 32'hBAD;
      @(negedge clk);                            // c2
      ack_man = 1'b0; start_i = 1'b1;
      @(negedge clk);                            // c3
      @(negedge clk); start_i = 1'b0;            // c4
      repeat (12) @(negedge clk);
      chk("t5_req_count", 64'(req_cnt), 64'd2);
      chk("t5_valid_count", 64'(valid_cnt), 64'd1);
      chk("t5_value", value_o, 64'h42);
      chk1("t5_idle", busy_o, 1'b0);

      // 6: reset mid-read in WAIT_HI
      silent_hi = 1'b1;
      cnt = 64'h99;
      @(negedge clk); start_i = 1'b1;            // c0
      @(negedge clk); start_i = 1'b0;            // c1
      repeat (4) @(negedge clk);                 // c5, WAIT_HI
      chk1("t6_busy_before", busy_o, 1'b1);
      reset = 1'b1;
      #1;
      chk1("t6_req_async", req_o, 1'b0);
      chk1("t6_busy_async", busy_o, 1'b0);
      chk("t6_value_zero", value_o, 64'h0);
      chk("t6_delta_zero", delta_o, 64'h0);
      valid_cnt = 0; to_cnt = 0;
      @(negedge clk);
      @(negedge clk); reset = 1'b0;
      silent_hi = 1'b0;
      repeat (25) @(negedge clk);
      chk("t6_no_valid", 64'(valid_cnt), 64'd0);
      chk("t6_no_timeout", 64'(to_cnt), 64'd0);
      do_read(64'h7);
      chk("t6_recover_value", value_o, 64'h7);
      chk("t6_recover_delta", delta_o, 64'h7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
